// File: rtl/ray_word_unpacker_if.sv
// Bundles the FIFO read side, the record handshake and the error counter
// of the ray word unpacker. The master modport is the unpacker itself.
interface ray_word_unpacker_if #(
  parameter int WORDS = 4,
  parameter int ERR_W = 16
);
  logic [35:0]         fifo_rd_data;
  logic                fifo_empty;
  logic                fifo_rd_en;
  logic [36*WORDS-1:0] rec_data;
  logic                rec_valid;
  logic                rec_ready;
  logic [ERR_W-1:0]    err_cnt;

  modport master (
    input  fifo_rd_data, fifo_empty, rec_ready,
    output fifo_rd_en, rec_data, rec_valid, err_cnt
  );

  modport slave (
    output fifo_rd_data, fifo_empty, rec_ready,
    input  fifo_rd_en, rec_data, rec_valid, err_cnt
  );
endinterface

// File: rtl/ray_word_unpacker.sv
// Pops 36-bit words from a synchronous FIFO and assembles WORDS-word records
// framed by a start marker in bit 35. Malformed words and partial records
// are dropped and counted in a saturating error counter.
//
// Assembly state:
//   state                  | meaning
//   complete=0, cnt=0      | idle, waiting for a start-marker word
//   complete=0, cnt=k>0    | k words of a record held in asm_buf
//   complete=1             | asm_buf holds a full record awaiting the output register
module ray_word_unpacker #(
  parameter int WORDS = 4,
  parameter int ERR_W = 16
) (
  input logic                clk,
  input logic                rst,
  ray_word_unpacker_if.master bus
);
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  logic                          pend_q;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [WORDS-1:0][35:0]        asm_q, asm_d;
  logic                          complete_q, complete_d;
  logic                          valid_q, valid_d;
  logic [36*WORDS-1:0]           data_q, data_d;
  logic [ERR_W-1:0]              err_q, err_d;
  logic                          rd_en;
  logic                          xfer;
  logic                          err_inc;
  logic [35:0]                   w;

  // State register: everything clears on the asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      asm_q      <= '0;
      complete_q <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      err_q      <= '0;
    end else begin
      pend_q     <= rd_en;
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      complete_q <= complete_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

  // Next state: output transfer, word arrival and error counting.
  always_comb begin
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    complete_d = complete_q;
    valid_d    = valid_q;
    data_d     = data_q;
    err_d      = err_q;
    err_inc    = 1'b0;
    w          = bus.fifo_rd_data;
    xfer       = complete_q && (!valid_q || bus.rec_ready);

    // A completed record moves to the output register when it is free or
    // being accepted this cycle; otherwise an accept empties it.
    if (xfer) begin
      data_d     = asm_q;
      valid_d    = 1'b1;
      complete_d = 1'b0;
    end else if (valid_q && bus.rec_ready) begin
      valid_d = 1'b0;
    end

    // The pop rule guarantees no word arrives while complete is set.
    if (pend_q) begin
      if (w[35]) begin
        if (cnt_q != '0) err_inc = 1'b1;
        asm_d[0] = w;
        cnt_d    = CW'(1);
      end else if (cnt_q == '0) begin
        err_inc = 1'b1;
      end else begin
        asm_d[cnt_q] = w;
        if (cnt_q == LAST) begin
          complete_d = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    if (err_inc && (err_q != {ERR_W{1'b1}})) err_d = err_q + 1'b1;
  end

  // Outputs: pop only when the returned word is guaranteed a slot.
  always_comb begin
    rd_en = !rst && !bus.fifo_empty && !complete_q && !(pend_q && (cnt_q == LAST));
    bus.fifo_rd_en = rd_en;
    bus.rec_data   = data_q;
    bus.rec_valid  = valid_q;
    bus.err_cnt    = err_q;
  end
endmodule

// File: tb/tb_ray_word_unpacker.sv
// Scoreboard bench for ray_word_unpacker: a FIFO model feeds the DUT,
// stimulus pushes expected records, a negedge monitor checks every accept.
module tb_ray_word_unpacker;
  localparam int WORDS = 4;
  localparam int ERR_W = 16;
  localparam int RW    = 36 * WORDS;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   pops = 0;

  logic [35:0]   fifo_q[$];
  logic [RW-1:0] exp_q[$];
  int            acc_cyc[$];

  logic [RW-1:0] stall_data;
  logic          stall_armed = 1'b0;

  ray_word_unpacker_if #(.WORDS(WORDS), .ERR_W(ERR_W)) bus ();

  ray_word_unpacker #(.WORDS(WORDS), .ERR_W(ERR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Cycle counter.
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous FIFO model: popped word appears the cycle after the pop.
  always @(posedge clk) begin
    if (bus.fifo_rd_en && fifo_q.size() > 0) begin
      bus.fifo_rd_data <= fifo_q.pop_front();
      pops = pops + 1;
    end
    bus.fifo_empty <= (fifo_q.size() == 0);
  end

  // Monitor: compare accepted records, check stability while stalled.
  always @(negedge clk) begin
    logic [RW-1:0] exp;
    if (!rst && bus.rec_valid) begin
      if (bus.rec_ready) begin
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL rec_unexpected: got %h, no record expected", bus.rec_data);
        end else begin
          exp = exp_q.pop_front();
          if (bus.rec_data !== exp) begin
            errors = errors + 1;
            $display("FAIL rec_data: got %h want %h", bus.rec_data, exp);
          end
        end
        acc_cyc.push_back(cyc);
        stall_armed = 1'b0;
      end else begin
        if (stall_armed) begin
          checks = checks + 1;
          if (bus.rec_data !== stall_data) begin
            errors = errors + 1;
            $display("FAIL rec_stable: got %h want %h", bus.rec_data, stall_data);
          end
        end
        stall_armed = 1'b1;
        stall_data  = bus.rec_data;
      end
    end else begin
      stall_armed = 1'b0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic push_word(input logic [35:0] wd);
    fifo_q.push_back(wd);
  endtask

  task automatic push_rec(input logic [35:0] w0, input logic [35:0] w1,
                          input logic [35:0] w2, input logic [35:0] w3);
    push_word(w0); push_word(w1); push_word(w2); push_word(w3);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check(name, 64'(n < limit), 64'd1);
  endtask

  initial begin
    int first_rd;
    int n;
    int pops0;
    bus.rec_ready = 1'b1;

    // Clean stream preloaded during reset so the FIFO is non-empty throughout.
    push_rec(36'h8_0000_0001, 36'h0_0000_0002, 36'h0_0000_0003, 36'h0_0000_0004);
    push_rec(36'h8_0000_0005, 36'h0_0000_0006, 36'h0_0000_0007, 36'h0_0000_0008);
    exp_q.push_back({36'h0_0000_0004, 36'h0_0000_0003, 36'h0_0000_0002, 36'h8_0000_0001});
    exp_q.push_back({36'h0_0000_0008, 36'h0_0000_0007, 36'h0_0000_0006, 36'h8_0000_0005});

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
      check("rst_valid", 64'(bus.rec_valid), 64'd0);
      check("rst_err", 64'(bus.err_cnt), 64'd0);
    end
    rst = 1'b0;
    #1;
    n = 0;
    while (!bus.fifo_rd_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("first_rd_en_seen", 64'(n < 20), 64'd1);
    first_rd = cyc;
    wait_drain("clean_drain", 200);
    check("clean_count", 64'(acc_cyc.size()), 64'd2);
    if (acc_cyc.size() == 2) begin
      // Both the pop cycle and the valid cycle are counted.
      check("clean_latency", 64'(acc_cyc[0] - first_rd + 1), 64'd7);
      check("clean_spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'd6);
    end
    check("clean_err", 64'(bus.err_cnt), 64'd0);

    // Resync: stray word dropped, following record intact.
    do_reset(2);
    push_word(36'h0_0000_00AA);
    push_rec(36'h8_0000_0009, 36'h0_0000_000A, 36'h0_0000_000B, 36'h0_0000_000C);
    exp_q.push_back({36'h0_0000_000C, 36'h0_0000_000B, 36'h0_0000_000A, 36'h8_0000_0009});
    wait_drain("resync_drain", 200);
    check("resync_err", 64'(bus.err_cnt), 64'd1);

    // Partial record superseded by a new marker.
    do_reset(2);
    push_word(36'h8_0000_0011);
    push_word(36'h0_0000_0012);
    push_rec(36'h8_0000_0015, 36'h0_0000_0016, 36'h0_0000_0017, 36'h0_0000_0018);
    exp_q.push_back({36'h0_0000_0018, 36'h0_0000_0017, 36'h0_0000_0016, 36'h8_0000_0015});
    wait_drain("partial_drain", 200);
    check("partial_err", 64'(bus.err_cnt), 64'd1);

    // Back-pressure with three records queued.
    do_reset(2);
    bus.rec_ready = 1'b0;
    pops0 = pops;
    push_rec(36'h8_0000_0021, 36'h0_0000_0022, 36'h0_0000_0023, 36'h0_0000_0024);
    push_rec(36'h8_0000_0025, 36'h0_0000_0026, 36'h0_0000_0027, 36'h0_0000_0028);
    push_rec(36'h8_0000_0029, 36'h0_0000_002A, 36'h0_0000_002B, 36'h0_0000_002C);
    exp_q.push_back({36'h0_0000_0024, 36'h0_0000_0023, 36'h0_0000_0022, 36'h8_0000_0021});
    exp_q.push_back({36'h0_0000_0028, 36'h0_0000_0027, 36'h0_0000_0026, 36'h8_0000_0025});
    exp_q.push_back({36'h0_0000_002C, 36'h0_0000_002B, 36'h0_0000_002A, 36'h8_0000_0029});
    repeat (30) @(negedge clk);
    check("bp_pops", 64'(pops - pops0), 64'd8);
    check("bp_valid", 64'(bus.rec_valid), 64'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    end
    acc_cyc.delete();
    bus.rec_ready = 1'b1;
    wait_drain("bp_drain", 200);
    check("bp_count", 64'(acc_cyc.size()), 64'd3);
    check("bp_total_pops", 64'(pops - pops0), 64'd12);
    check("bp_err", 64'(bus.err_cnt), 64'd0);

    // Reset in the middle of a record.
    do_reset(2);
    push_word(36'h8_0000_0031);
    push_word(36'h0_0000_0032);
    n = 0;
    while (fifo_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("mid_partial_popped", 64'(fifo_q.size()), 64'd0);
    acc_cyc.delete();
    do_reset(2);
    check("mid_valid_after_rst", 64'(bus.rec_valid), 64'd0);
    push_rec(36'h8_0000_0035, 36'h0_0000_0036, 36'h0_0000_0037, 36'h0_0000_0038);
    exp_q.push_back({36'h0_0000_0038, 36'h0_0000_0037, 36'h0_0000_0036, 36'h8_0000_0035});
    wait_drain("mid_drain", 200);
    check("mid_count", 64'(acc_cyc.size()), 64'd1);
    check("mid_err", 64'(bus.err_cnt), 64'd0);

    // Saturation: more stray words than the counter can represent.
    do_reset(2);
    for (int i = 0; i < 70000; i++) push_word(36'(i + 1));
    wait_drain("sat_drain", 72000);
    check("sat_err", 64'(bus.err_cnt), 64'hFFFF);
    check("sat_no_rec", 64'(bus.rec_valid), 64'd0);

    check("exp_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end
endmodule
